id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and EX operand-select stage; feeds the 32-bit CLA ALU directly.
//  Registers decoded ID outputs, generates the 4-bit ALUctl, forwards from EX/MEM and MEM/WB,
//  and detects load-use hazards. Outputs alu_a/alu_b/alu_ctl connect straight to the ALU.
// PARAMETERS
//  W     32  datapath width
//  RW    5   register index width
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  stall_in      in   1   downstream stall; hold all stage state
//  flush_in      in   1   branch/jump flush; load bubble
//  id_valid      in   1   ID slot holds a real instruction
//  id_alu_op     in   2   00 add, 01 sub, 10 use funct, 11 or
//  id_funct      in   6   R-type funct field
//  id_rs_data    in   W   register-file read A
//  id_rt_data    in   W   register-file read B
//  id_imm        in   W   extended immediate (sign/zero decided in ID)
//  id_alu_src    in   1   1: ALU B = imm
//  id_rs,id_rt   in   RW  source indices
//  id_uses_rt    in   1   instruction reads rt as a source
//  id_rd         in   RW  destination index (reg_dst already resolved)
//  id_reg_write,id_mem_read,id_mem_write,id_mem_to_reg  in 1 each  control
//  exmem_reg_write in 1, exmem_rd in RW, exmem_result in W   forward source 1
//  memwb_reg_write in 1, memwb_rd in RW, memwb_result in W   forward source 2
//  alu_a,alu_b   out  W   ALU operands (post-forward, post-imm mux)
//  alu_ctl       out  4   {inv_a,inv_b/cin,sel[1:0]} to ALU
//  store_data    out  W   forwarded rt value for sw
//  ex_rd         out  RW  destination index
//  ex_valid,ex_reg_write,ex_mem_read,ex_mem_write,ex_mem_to_reg  out 1 each
//  ex_illegal    out  1   unknown funct under alu_op=10 (registered)
//  hazard_stall  out  1   load-use stall request to IF/ID (combinational)
// BEHAVIOUR
//  - Reset: every register is 0 (alu_ctl=0000, ex_valid=0, all control bits 0, ex_illegal=0).
//  - Edge priority: rst > flush_in > stall_in > hazard_stall > load ID.
//    flush, or hazard without stall: bubble (valid/reg_write/mem_*/illegal=0; data don't-care, held 0).
//    stall_in: hold everything, including during flush-free hazard.
//  - Bubble control bits are forced 0 regardless of id_valid; id_valid=0 loads a bubble.
//  - Latency: 1 cycle from ID inputs to alu_ctl/ex_* outputs; forwarding is combinational in EX.
//  - ALUctl decode (registered): alu_op 00->0010, 01->0110, 11->0001;
//    alu_op 10 funct 20/21->0010, 22/23->0110, 24->0000, 25->0001, 27->1100 (nor), 2A->0111;
//    any other funct->0010 and ex_illegal=1.
//  - Forward A (rs), same for B (rt): EX/MEM when exmem_reg_write & exmem_rd!=0 & exmem_rd==rs;
//    else MEM/WB when memwb_reg_write & memwb_rd!=0 & memwb_rd==rs; else registered data.
//    EX/MEM wins when both match. Index 0 never forwarded.
//  - alu_b = alu_src ? imm : fwd_rt; store_data = fwd_rt always.
//  - hazard_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid &
//    (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)). Released the cycle after the bubble loads.
//  - Reset mid-hazard: state cleared, hazard_stall drops asynchronously with ex_valid.
// STRUCTURE
//  - Shared header pipe_defs.vh: ALUCTL_AND/OR/ADD/SUB/SLT/NOR, ALUOP_* codes, FUNCT_* codes.
//  - Sub-module alu_ctl_decode (combinational alu_op+funct -> alu_ctl, illegal).
//  - Forward muxes and hazard logic inline.
// TESTING
//  1 Reset: rst=1 mid-run -> all ex_* 0, alu_ctl=0000, hazard_stall=0 same cycle.
//  2 Decode: alu_op=10 funct 22 -> alu_ctl=0110; funct 27 -> 1100; funct 3F -> 0010, ex_illegal=1.
//  3 Forward: rs=5, exmem_rd=5 result 0x11, memwb_rd=5 result 0x22 -> alu_a=0x11;
//    exmem_reg_write=0 -> alu_a=0x22; rs=0 with rd=0 matches -> alu_a=registered data.
//  4 Load-use: EX holds lw rd=8; ID add rs=8 -> hazard_stall=1, next cycle ex_valid=0 bubble,
//    hazard_stall=0; following cycle add loads with alu_a forwarded from MEM/WB.
//  5 Stall vs flush: stall_in=1 holds alu_ctl/alu_b 3 cycles; flush_in+stall_in together -> bubble.
//  6 Store: sw alu_src=1 imm=0x10, rt forwarded 0xABCD from EX/MEM -> alu_b=0x10, store_data=0xABCD.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU control codes, ALU op classes and R-type funct codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package id_ex_stage_pkg;

  // 4-bit ALU control: {inv_a, inv_b/cin, sel[1:0]}
  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;

  // ALU op class produced by the main decoder in ID
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  // R-type funct codes understood by the ALU
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // Registered control slice of the ID/EX stage; an all-zero value is a bubble
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       illegal;
    logic       alu_src;
    logic [3:0] alu_ctl;
  } ex_ctl_t;

  localparam ex_ctl_t EX_CTL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_alu_ctl_decode.sv
// Combinational ALU control decoder: alu_op + funct -> 4-bit ALU control and illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
module alu_ctl_decode
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o,
  output logic       illegal_o
);

  // Map op class / funct to ALU control; unknown funct falls back to add and flags illegal
  always_comb begin
    alu_ctl_o = ALUCTL_ADD;
    illegal_o = 1'b0;
    case (alu_op_e'(alu_op_i))
      ALUOP_ADD: alu_ctl_o = ALUCTL_ADD;
      ALUOP_SUB: alu_ctl_o = ALUCTL_SUB;
      ALUOP_OR:  alu_ctl_o = ALUCTL_OR;
      default: begin
        case (funct_i)
          FUNCT_ADD, FUNCT_ADDU: alu_ctl_o = ALUCTL_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctl_o = ALUCTL_SUB;
          FUNCT_AND:             alu_ctl_o = ALUCTL_AND;
          FUNCT_OR:              alu_ctl_o = ALUCTL_OR;
          FUNCT_NOR:             alu_ctl_o = ALUCTL_NOR;
          FUNCT_SLT:             alu_ctl_o = ALUCTL_SLT;
          default: begin
            alu_ctl_o = ALUCTL_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand select (forwarding, imm mux) feeding the ALU; load-use detect.
// Latency: 1 cycle ID -> EX registers; forwarding and hazard_stall are combinational.
// Backpressure: stall_in holds all state; flush_in or a load-use hazard loads a bubble.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          flush_in,
  input  logic          id_valid,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic [W-1:0]  id_rs_data,
  input  logic [W-1:0]  id_rt_data,
  input  logic [W-1:0]  id_imm,
  input  logic          id_alu_src,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_result,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_ctl,
  output logic [W-1:0]  store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_illegal,
  output logic          hazard_stall
);

  ex_ctl_t       ctl_q, ctl_d;
  logic [W-1:0]  rs_data_q, rs_data_d;
  logic [W-1:0]  rt_data_q, rt_data_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;

  logic [3:0]    dec_ctl;
  logic          dec_illegal;
  logic [W-1:0]  fwd_rs;
  logic [W-1:0]  fwd_rt;

  alu_ctl_decode u_alu_ctl_decode (
    .alu_op_i  (id_alu_op),
    .funct_i   (id_funct),
    .alu_ctl_o (dec_ctl),
    .illegal_o (dec_illegal)
  );

  // Load in EX whose destination is read by the ID instruction: stall IF/ID and insert a bubble
  always_comb begin
    hazard_stall = ctl_q.valid & ctl_q.mem_read & (rd_q != '0) & id_valid &
                   ((rd_q == id_rs) | (id_uses_rt & (rd_q == id_rt)));
  end

  // Next stage contents: flush beats stall, stall holds, hazard or empty ID slot gives a bubble
  always_comb begin
    ctl_d     = ctl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (flush_in || (!stall_in && (hazard_stall || !id_valid))) begin
      ctl_d     = EX_CTL_BUBBLE;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end else if (!stall_in) begin
      ctl_d.valid      = 1'b1;
      ctl_d.reg_write  = id_reg_write;
      ctl_d.mem_read   = id_mem_read;
      ctl_d.mem_write  = id_mem_write;
      ctl_d.mem_to_reg = id_mem_to_reg;
      ctl_d.illegal    = dec_illegal;
      ctl_d.alu_src    = id_alu_src;
      ctl_d.alu_ctl    = dec_ctl;
      rs_data_d        = id_rs_data;
      rt_data_d        = id_rt_data;
      imm_d            = id_imm;
      rs_d             = id_rs;
      rt_d             = id_rt;
      rd_d             = id_rd;
    end
  end

  // Stage register; reset clears everything so hazard_stall drops with ex_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q     <= EX_CTL_BUBBLE;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctl_q     <= ctl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  // Operand forwarding: youngest producer (EX/MEM) first, register 0 is never forwarded
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
      fwd_rs = memwb_result;
    end
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
      fwd_rt = memwb_result;
    end
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = ctl_q.alu_src ? imm_q : fwd_rt;
  assign store_data    = fwd_rt;
  assign alu_ctl       = ctl_q.alu_ctl;
  assign ex_rd         = rd_q;
  assign ex_valid      = ctl_q.valid;
  assign ex_reg_write  = ctl_q.reg_write;
  assign ex_mem_read   = ctl_q.mem_read;
  assign ex_mem_write  = ctl_q.mem_write;
  assign ex_mem_to_reg = ctl_q.mem_to_reg;
  assign ex_illegal    = ctl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model tracks the one-cycle ID->EX register; forwarding checked combinationally.
// Backpressure: stall_in/flush_in/reset driven directly and mirrored in the model.
module tb_id_ex_stage;

  localparam int W  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_in, flush_in;
  logic          id_valid;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic [W-1:0]  id_rs_data, id_rt_data, id_imm;
  logic          id_alu_src;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_uses_rt;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [W-1:0]  exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [W-1:0]  memwb_result;
  logic [W-1:0]  alu_a, alu_b, store_data;
  logic [3:0]    alu_ctl;
  logic [RW-1:0] ex_rd;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          ex_illegal, hazard_stall;

  int checks   = 0;
  int failures = 0;

  // Model of what the EX slot holds
  logic          m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill, m_src;
  logic [3:0]    m_ctl;
  logic [W-1:0]  m_rsd, m_rtd, m_imm;
  logic [RW-1:0] m_rs, m_rt, m_rd;

  always #5 clk = ~clk;

  id_ex_stage #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .store_data(store_data),
    .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {illegal, alu_ctl} straight from the decode table
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b11) return 5'b0_0001;
    case (f)
      6'h20, 6'h21: return 5'b0_0010;
      6'h22, 6'h23: return 5'b0_0110;
      6'h24:        return 5'b0_0000;
      6'h25:        return 5'b0_0001;
      6'h27:        return 5'b0_1100;
      6'h2A:        return 5'b0_0111;
      default:      return 5'b1_0010;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_fwd(input logic [RW-1:0] idx, input logic [W-1:0] d);
    if (exmem_reg_write && idx != 0 && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && idx != 0 && memwb_rd == idx) return memwb_result;
    return d;
  endfunction

  function automatic logic ref_hazard();
    return m_valid && m_mr && m_rd != 0 && id_valid &&
           (m_rd == id_rs || (id_uses_rt && m_rd == id_rt));
  endfunction

  task automatic model_clear();
    {m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill, m_src} = '0;
    m_ctl = '0; m_rsd = '0; m_rtd = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
  endtask

  // Advance model by one edge using the inputs currently applied, then step past the edge
  task automatic tick();
    logic [4:0] dec;
    if (rst || flush_in) model_clear();
    else if (stall_in) begin end
    else if (ref_hazard() || !id_valid) model_clear();
    else begin
      dec = ref_decode(id_alu_op, id_funct);
      m_valid = 1'b1; m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
      m_m2r = id_mem_to_reg; m_ill = dec[4]; m_ctl = dec[3:0]; m_src = id_alu_src;
      m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".alu_a"}, alu_a, ref_fwd(m_rs, m_rsd));
    chk({tag, ".alu_b"}, alu_b, m_src ? m_imm : ref_fwd(m_rt, m_rtd));
    chk({tag, ".store_data"}, store_data, ref_fwd(m_rt, m_rtd));
    chk({tag, ".alu_ctl"}, {28'd0, alu_ctl}, {28'd0, m_ctl});
    chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, m_rd});
    chk({tag, ".ctl"}, {26'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal},
        {26'd0, m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill});
    chk({tag, ".hazard"}, {31'd0, hazard_stall}, {31'd0, ref_hazard()});
  endtask

  task automatic set_id(input logic [1:0] op, input logic [5:0] f,
                        input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                        input logic [W-1:0] rsd, input logic [W-1:0] rtd, input logic [W-1:0] imm,
                        input logic src, input logic uses_rt,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = 1'b1; id_alu_op = op; id_funct = f; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src = src; id_uses_rt = uses_rt;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    set_id(2'b00, 6'h00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    clear_fwd();
    model_clear();
    #1;
    // Reset state
    chk("reset.alu_ctl", {28'd0, alu_ctl}, 32'd0);
    chk("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_all("reset");
    tick();
    rst = 1'b0;

    // Decode
    set_id(2'b10, 6'h22, 1, 2, 3, 32'h10, 32'h20, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("dec.sub", {28'd0, alu_ctl}, 32'h6);
    check_all("dec22");
    id_funct = 6'h27;
    tick();
    chk("dec.nor", {28'd0, alu_ctl}, 32'hC);
    check_all("dec27");
    id_funct = 6'h3F;
    tick();
    chk("dec.bad_ctl", {28'd0, alu_ctl}, 32'h2);
    chk("dec.bad_ill", {31'd0, ex_illegal}, 32'd1);
    check_all("dec3f");

    // Forwarding priority and register 0
    set_id(2'b00, 6'h00, 5, 6, 7, 32'h99, 32'h98, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5; memwb_result = 32'h22;
    #1;
    chk("fwd.exmem", alu_a, 32'h11);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd.memwb", alu_a, 32'h22);
    check_all("fwd.memwb");
    set_id(2'b00, 6'h00, 0, 6, 7, 32'h77, 32'h98, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 0; memwb_rd = 0;
    tick();
    chk("fwd.zero", alu_a, 32'h77);
    check_all("fwd.zero");

    // Store with forwarded rt
    clear_fwd();
    set_id(2'b00, 6'h00, 1, 9, 0, 32'h100, 32'h5, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 9; exmem_result = 32'hABCD;
    #1;
    chk("sw.alu_b", alu_b, 32'h10);
    chk("sw.store_data", store_data, 32'hABCD);
    check_all("sw");

    // Load-use
    clear_fwd();
    set_id(2'b00, 6'h00, 1, 0, 8, 32'h200, 0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(2'b10, 6'h20, 8, 2, 3, 32'h1, 32'h2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu.hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("lu.bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu.release", {31'd0, hazard_stall}, 32'd0);
    check_all("lu.bubble");
    memwb_reg_write = 1'b1; memwb_rd = 8; memwb_result = 32'h1234;
    tick();
    chk("lu.valid", {31'd0, ex_valid}, 32'd1);
    chk("lu.fwd", alu_a, 32'h1234);
    check_all("lu.add");

    // Reset in the middle of a load-use hazard
    clear_fwd();
    set_id(2'b00, 6'h00, 1, 0, 8, 32'h200, 0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(2'b10, 6'h20, 8, 2, 3, 32'h1, 32'h2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst.pre_hazard", {31'd0, hazard_stall}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.hazard", {31'd0, hazard_stall}, 32'd0);
    chk("rst.alu_ctl", {28'd0, alu_ctl}, 32'd0);
    check_all("rst.mid");
    tick();
    rst = 1'b0;

    // Stall holds, flush wins over stall
    set_id(2'b01, 6'h00, 1, 2, 3, 32'h1, 32'h2, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    stall_in = 1'b1;
    set_id(2'b11, 6'h00, 4, 5, 6, 32'h3, 32'h4, 32'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.alu_ctl", {28'd0, alu_ctl}, 32'h6);
      chk("stall.alu_b", alu_b, 32'h55);
    end
    flush_in = 1'b1;
    tick();
    chk("flush.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_all("flush");
    flush_in = 1'b0; stall_in = 1'b0;

    // Randomized traffic with narrow index range to exercise forwarding and hazards
    for (int n = 0; n < 400; n++) begin
      logic [5:0] f;
      case ($urandom_range(0, 8))
        0: f = 6'h20; 1: f = 6'h21; 2: f = 6'h22; 3: f = 6'h23;
        4: f = 6'h24; 5: f = 6'h25; 6: f = 6'h27; 7: f = 6'h2A;
        default: f = 6'($urandom);
      endcase
      set_id(2'($urandom), f, RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             RW'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
             1'($urandom), 1'($urandom));
      id_valid        = ($urandom_range(0, 5) != 0);
      stall_in        = ($urandom_range(0, 7) == 0);
      flush_in        = ($urandom_range(0, 9) == 0);
      rst             = ($urandom_range(0, 49) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = RW'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = RW'($urandom_range(0, 3)); memwb_result = $urandom;
      if (rst) model_clear();
      #1;
      check_all("rand.pre");
      tick();
      check_all("rand.post");
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
